// File: rtl/pmcc_pkg.sv
// Shared types for the PMC coprocessor trigger generator.
//   pmcc_trig_mode_t  : operating mode selected by the control registers
//   pmcc_trig_state_t : trigger generator FSM state
//   decode_mode()     : maps the raw 2-bit mode field (3 aliases one-shot)
package pmcc_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_EXTERNAL = 2'd2
    } pmcc_trig_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DELAY     = 3'd1,
        ST_PERIOD    = 3'd2,
        ST_EXT_WAIT  = 3'd3,
        ST_EXT_DELAY = 3'd4
    } pmcc_trig_state_t;

    function automatic pmcc_trig_mode_t decode_mode(input logic [1:0] raw);
        pmcc_trig_mode_t m;
        case (raw)
            2'd1:    m = MODE_PERIODIC;
            2'd2:    m = MODE_EXTERNAL;
            default: m = MODE_ONESHOT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pmcc_sync_edge_detector.sv
// Synchronizes an asynchronous level into clk and flags its rising edge.
//   clk, rst  : block clock, async active-high reset
//   i_din     : asynchronous input level
//   o_rise    : one-cycle pulse when the synchronized level goes 0 -> 1
module pmcc_sync_edge_detector #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/pmcc_trigger_generator.sv
// Generates the single-cycle trigger that releases a PMC wait instruction.
// Modes: one-shot delayed, periodic burst, synchronized external event.
//   clk, rst       : block clock, async active-high reset
//   start, stop    : arm (samples configuration) / abort pulses
//   mode, delay, period, burst_len : configuration, captured on accepted start
//   ext_event      : asynchronous external event (rising edge used)
//   trigger        : one-cycle pulse to the wait logic
//   busy           : high whenever the FSM is not IDLE
//   trigger_count  : triggers since the last start, saturating
module pmcc_trigger_generator
    import pmcc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned BURST_WIDTH = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [CNT_WIDTH-1:0]   delay,
    input  logic [CNT_WIDTH-1:0]   period,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   ext_event,
    output logic                   trigger,
    output logic                   busy,
    output logic [BURST_WIDTH-1:0] trigger_count
);

    pmcc_trig_state_t       r_state, w_state_nxt;
    pmcc_trig_mode_t        r_mode, w_start_mode;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0]   r_delay, r_period_m1;
    logic [BURST_WIDTH-1:0] r_burst, r_tcount;
    logic                   r_trig, r_busy;
    logic                   w_trig_nxt, w_busy_nxt;
    logic                   w_rise, w_accept, w_fire, w_last;

    pmcc_sync_edge_detector #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (ext_event),
        .o_rise (w_rise)
    );

    assign w_start_mode = decode_mode(mode);
    assign w_accept     = (r_state == ST_IDLE) & start & ~stop;
    // A stop in the trigger cycle cancels the pulse already scheduled
    assign w_fire       = r_trig & ~stop;
    // The trigger firing now is the last one of a finite burst
    assign w_last       = (r_burst != '0) &&
                          ((r_tcount + BURST_WIDTH'(1)) == r_burst);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and counter logic; a counter value of 0 is the trigger cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = (w_start_mode == MODE_EXTERNAL) ? ST_EXT_WAIT : ST_DELAY;
                        w_cnt_nxt   = delay;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == '0) begin
                        if ((r_mode == MODE_ONESHOT) || w_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_PERIOD;
                            w_cnt_nxt   = r_period_m1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                    end
                end
                ST_PERIOD: begin
                    if (r_cnt == '0) begin
                        if (w_last) w_state_nxt = ST_IDLE;
                        else        w_cnt_nxt   = r_period_m1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                    end
                end
                ST_EXT_WAIT: begin
                    if (w_rise) begin
                        w_state_nxt = ST_EXT_DELAY;
                        w_cnt_nxt   = r_delay;
                    end
                end
                ST_EXT_DELAY: begin
                    // Edges seen here are dropped: only EXT_WAIT looks at w_rise
                    if (r_cnt == '0) w_state_nxt = w_last ? ST_IDLE : ST_EXT_WAIT;
                    else             w_cnt_nxt   = r_cnt - CNT_WIDTH'(1);
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode on the next state so trigger/busy line up with it
    always_comb begin
        w_trig_nxt = 1'b0;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        if ((w_state_nxt == ST_DELAY) || (w_state_nxt == ST_PERIOD) ||
            (w_state_nxt == ST_EXT_DELAY)) begin
            w_trig_nxt = (w_cnt_nxt == '0);
        end
    end

    // Counter, captured configuration, outputs and trigger count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mode      <= MODE_ONESHOT;
            r_delay     <= '0;
            r_period_m1 <= '0;
            r_burst     <= '0;
            r_tcount    <= '0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_trig <= w_trig_nxt;
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_mode      <= w_start_mode;
                r_delay     <= delay;
                r_period_m1 <= (period == '0) ? '0 : period - CNT_WIDTH'(1);
                r_burst     <= burst_len;
                r_tcount    <= '0;
            end else if (w_fire && (r_tcount != '1)) begin
                r_tcount <= r_tcount + BURST_WIDTH'(1);
            end
        end
    end

    assign trigger       = w_fire;
    assign busy          = r_busy;
    assign trigger_count = r_tcount;

endmodule

// File: tb/tb_pmcc_trigger_generator.sv
// Self-checking bench for pmcc_trigger_generator: directed and random
// configurations checked cycle by cycle against a trigger-schedule model.
module tb_pmcc_trigger_generator;

    localparam int unsigned CW  = 16;
    localparam int unsigned BW  = 8;
    localparam int unsigned SS  = 2;
    localparam int          HOR = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, ext_event;
    logic [1:0]    mode;
    logic [CW-1:0] delay, period;
    logic [BW-1:0] burst_len;
    logic          trigger, busy;
    logic [BW-1:0] trigger_count;

    pmcc_trigger_generator #(
        .CNT_WIDTH   (CW),
        .BURST_WIDTH (BW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .mode          (mode),
        .delay         (delay),
        .period        (period),
        .burst_len     (burst_len),
        .ext_event     (ext_event),
        .trigger       (trigger),
        .busy          (busy),
        .trigger_count (trigger_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int prev_cnt = 0;

    bit ext_wave [HOR];
    bit exp_trig [HOR];
    bit exp_busy [HOR];
    int exp_cnt  [HOR];
    int trig_q[$];

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic clear_wave();
        for (int i = 0; i < HOR; i++) ext_wave[i] = 1'b0;
    endtask

    // Random pulses on ext_event, quiet at both ends of the window
    task automatic rand_wave();
        int pos, hi;
        clear_wave();
        pos = int'($urandom_range(5, 15));
        while (pos < HOR - 20) begin
            hi = int'($urandom_range(1, 4));
            for (int i = 0; i < hi; i++) ext_wave[pos + i] = 1'b1;
            pos = pos + hi + int'($urandom_range(2, 12));
        end
    endtask

    task automatic set_pulse(input int at, input int len);
        for (int i = 0; i < len; i++) ext_wave[at + i] = 1'b1;
    endtask

    // Trigger schedule from the mode rules: start at cycle s, stop at cycle t
    task automatic build_model(input int m, input int d, input int p, input int b,
                               input int s, input int t);
        int md, per, k, tt, ready, v, last_end, n;
        bit done;
        trig_q.delete();
        md = (m == 3) ? 0 : m;
        per = (p == 0) ? 1 : p;
        k = 0;
        done = 1'b0;
        if (s != t) begin
            if (md < 2) begin
                tt = s + 1 + d;
                while (tt < t) begin
                    trig_q.push_back(tt);
                    k++;
                    if (md == 0 || (b != 0 && k == b)) begin
                        done = 1'b1;
                        break;
                    end
                    tt = tt + per;
                end
            end else begin
                ready = s + 1;
                for (int e = 1; e < HOR; e++) begin
                    if (!(ext_wave[e] && !ext_wave[e-1])) continue;
                    v = e + SS;
                    if (v < ready) continue;
                    tt = v + 1 + d;
                    if (tt >= t) break;
                    trig_q.push_back(tt);
                    k++;
                    ready = tt + 1;
                    if (b != 0 && k == b) begin
                        done = 1'b1;
                        break;
                    end
                end
            end
        end
        last_end = done ? trig_q[$] : t;
        for (int c = 0; c < HOR; c++) begin
            exp_trig[c] = 1'b0;
            foreach (trig_q[i]) if (trig_q[i] == c) exp_trig[c] = 1'b1;
            exp_busy[c] = (s != t) && (c >= s + 1) && (c <= last_end);
            if (s != t && c > s) begin
                n = 0;
                foreach (trig_q[i]) if (trig_q[i] < c) n++;
                exp_cnt[c] = (n > 255) ? 255 : n;
            end else begin
                exp_cnt[c] = prev_cnt;
            end
        end
        prev_cnt = exp_cnt[HOR-1];
    endtask

    // Drive one scenario and compare every cycle; xs is an extra start while busy
    task automatic run_test(input string tag, input int m, input int d, input int p,
                            input int b, input int s, input int t, input int xs);
        build_model(m, d, p, b, s, t);
        for (int c = 0; c < HOR; c++) begin
            @(posedge clk);
            #1;
            start     = (c == s) || (c == xs);
            stop      = (c == t);
            ext_event = ext_wave[c];
            if (c == s) begin
                mode      = 2'(m);
                delay     = CW'(d);
                period    = CW'(p);
                burst_len = BW'(b);
            end else begin
                mode      = 2'($urandom);
                delay     = CW'($urandom_range(0, 20));
                period    = CW'($urandom_range(0, 9));
                burst_len = BW'($urandom_range(0, 6));
            end
            @(negedge clk);
            check($sformatf("%s_trig", tag), c, 32'(trigger), 32'(exp_trig[c]));
            check($sformatf("%s_busy", tag), c, 32'(busy), 32'(exp_busy[c]));
            check($sformatf("%s_cnt", tag), c, 32'(trigger_count), 32'(exp_cnt[c]));
        end
    endtask

    initial begin
        int m, d, p, b, s, t;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        ext_event = 1'b0;
        mode = 2'd0;
        delay = '0;
        period = '0;
        burst_len = '0;
        clear_wave();

        @(posedge clk);
        #1;
        check("reset_trig", 0, 32'(trigger), 32'd0);
        check("reset_busy", 0, 32'(busy), 32'd0);
        check("reset_cnt", 0, 32'(trigger_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_test("oneshot",   0, 5, 0, 0, 10, HOR-2, -1);
        run_test("periodic",  1, 0, 4, 3, 0, HOR-2, -1);
        run_test("unlimited", 1, 0, 0, 0, 2, 20, -1);
        clear_wave();
        set_pulse(30, 2);
        set_pulse(33, 2);
        set_pulse(45, 3);
        set_pulse(60, 2);
        run_test("external",  2, 2, 0, 2, 5, HOR-2, -1);
        clear_wave();
        run_test("startstop", 0, 3, 0, 0, 10, 10, -1);
        run_test("busystart", 0, 8, 0, 0, 10, HOR-2, 13);
        run_test("mode3",     3, 4, 2, 3, 7, HOR-2, -1);
        run_test("saturate",  1, 0, 1, 0, 2, HOR-10, -1);

        for (int r = 0; r < 12; r++) begin
            m = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 5));
            b = int'($urandom_range(0, 4));
            s = int'($urandom_range(2, 20));
            t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(s + 3, HOR - 2)) : HOR - 2;
            rand_wave();
            run_test($sformatf("rand%0d", r), m, d, p, b, s, t, -1);
        end

        // Asynchronous reset in the middle of a periodic run
        clear_wave();
        @(posedge clk);
        #1;
        start = 1'b1;
        stop = 1'b0;
        mode = 2'd1;
        delay = CW'(0);
        period = CW'(3);
        burst_len = BW'(0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_trig", 0, 32'(trigger), 32'd0);
        check("rst_async_busy", 0, 32'(busy), 32'd0);
        check("rst_async_cnt", 0, 32'(trigger_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_trig", c, 32'(trigger), 32'd0);
            check("post_rst_busy", c, 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
